// File: rtl/ncl_qhost_pkg.sv
// Shared types and rail encode/decode helpers for the quaternary NCL adder host.
package ncl_qhost_pkg;

  localparam int Q_WIDTH  = 4;
  localparam int DR_WIDTH = 2;

  typedef enum logic [1:0] {TX_IDLE, TX_DATA, TX_RTZ} tx_state_t;
  typedef enum logic       {RX_WAIT, RX_ACK}          rx_state_t;

  function automatic logic [Q_WIDTH-1:0] onehot4(input logic [1:0] v);
    return 4'b0001 << v;
  endfunction

  // Lowest set rail wins, so a malformed wavefront still decodes deterministically.
  function automatic logic [1:0] decode4(input logic [Q_WIDTH-1:0] q);
    if (q[0])      return 2'd0;
    else if (q[1]) return 2'd1;
    else if (q[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  function automatic logic [DR_WIDTH-1:0] dr_encode(input logic b);
    return b ? 2'b10 : 2'b01;
  endfunction

  function automatic logic dr_decode(input logic [DR_WIDTH-1:0] r);
    return r[1];
  endfunction

  function automatic logic q_exactly_one(input logic [Q_WIDTH-1:0] q);
    return (q != '0) && ((q & (q - 4'd1)) == '0);
  endfunction

  function automatic logic q_multi(input logic [Q_WIDTH-1:0] q);
    return (q & (q - 4'd1)) != '0;
  endfunction

endpackage

// File: rtl/ncl_quad_adder_host_if.sv
// Synchronous-side operand/result handshakes of the NCL adder host.
interface ncl_quad_adder_host_if;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_a;
  logic [1:0] in_b;
  logic       in_cin;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_sum;
  logic       out_cout;

  modport master (output in_valid, in_a, in_b, in_cin, out_ready,
                  input  in_ready, out_valid, out_sum, out_cout);
  modport slave  (input  in_valid, in_a, in_b, in_cin, out_ready,
                  output in_ready, out_valid, out_sum, out_cout);
endinterface

// File: rtl/ncl_sync.sv
// Single-bit flop-chain synchroniser, asynchronously cleared by init_n.
module ncl_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic init_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) chain <= '0;
    else         chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/ncl_quad_adder_host.sv
// Clocked four-phase producer/consumer around one quaternary NCL full-adder digit.
// Optional rail checking enabled by defining NCL_QHOST_RAILCHK_EN.
module ncl_quad_adder_host
  import ncl_qhost_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TMO_CYCLES  = 1024
) (
  input  logic                clk,
  input  logic                init_n,
  ncl_quad_adder_host_if.slave hif,
  output logic [Q_WIDTH-1:0]  AQ,
  output logic [Q_WIDTH-1:0]  BQ,
  output logic [DR_WIDTH-1:0] carryin,
  input  logic                ABCOMP,
  input  logic                sumcarryCOMP,
  input  logic [Q_WIDTH-1:0]  sumQ,
  input  logic [DR_WIDTH-1:0] carryout,
  output logic                sumCOMP,
  output logic                carryCOMP,
  output logic                err_timeout,
  output logic                err_rail
);

  localparam int NSYNC = 2 + Q_WIDTH + DR_WIDTH;
  localparam int CW    = $clog2(TMO_CYCLES + 1);

  logic [NSYNC-1:0]    async_in, sync_q;
  logic                abcomp_s, sccomp_s;
  logic [Q_WIDTH-1:0]  sumq_s;
  logic [DR_WIDTH-1:0] cout_s;

  assign async_in = {carryout, sumQ, sumcarryCOMP, ABCOMP};

  for (genvar i = 0; i < NSYNC; i++) begin : g_sync
    ncl_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk    (clk),
      .init_n (init_n),
      .d      (async_in[i]),
      .q      (sync_q[i])
    );
  end

  assign abcomp_s = sync_q[0];
  assign sccomp_s = sync_q[1];
  assign sumq_s   = sync_q[2 +: Q_WIDTH];
  assign cout_s   = sync_q[2+Q_WIDTH +: DR_WIDTH];

  tx_state_t tx_state, tx_next;
  rx_state_t rx_state, rx_next;
  logic      run, in_ready, accept;
  logic      sum_ok, c_ok, rx_load;
  logic      out_valid, out_cout;
  logic [1:0] out_sum;
  logic [CW-1:0] tmo_cnt;
  logic      idle_both, st_change;

  // run keeps in_ready low during reset and for the release edge itself
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) run <= 1'b0;
    else         run <= 1'b1;
  end

  assign in_ready = run && (tx_state == TX_IDLE) && !abcomp_s && !sccomp_s;
  assign accept   = hif.in_valid && in_ready;

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE: if (accept)                  tx_next = TX_DATA;
      TX_DATA: if (abcomp_s && sccomp_s)    tx_next = TX_RTZ;
      TX_RTZ:  if (!abcomp_s && !sccomp_s)  tx_next = TX_IDLE;
      default:                              tx_next = TX_IDLE;
    endcase
  end

`ifdef NCL_QHOST_RAILCHK_EN
  logic rail_bad;
  assign sum_ok   = q_exactly_one(sumq_s);
  assign c_ok     = ^cout_s;
  assign rail_bad = q_multi(sumq_s) || (&cout_s);

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n)       err_rail <= 1'b0;
    else if (rail_bad) err_rail <= 1'b1;
  end
`else
  assign sum_ok   = |sumq_s;
  assign c_ok     = |cout_s;
  assign err_rail = 1'b0;
`endif

  assign rx_load = (rx_state == RX_WAIT) && sum_ok && c_ok && (!out_valid || hif.out_ready);

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_WAIT: if (rx_load)                          rx_next = RX_ACK;
      RX_ACK:  if ((sumq_s == '0) && (cout_s == '0)) rx_next = RX_WAIT;
      default:                                       rx_next = RX_WAIT;
    endcase
  end

  // ---- state, NCL-side rail and acknowledge flops ----
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      tx_state  <= TX_IDLE;
      rx_state  <= RX_WAIT;
      AQ        <= '0;
      BQ        <= '0;
      carryin   <= '0;
      sumCOMP   <= 1'b0;
      carryCOMP <= 1'b0;
    end else begin
      tx_state  <= tx_next;
      rx_state  <= rx_next;
      sumCOMP   <= (rx_next == RX_ACK);
      carryCOMP <= (rx_next == RX_ACK);
      if (accept) begin
        AQ      <= onehot4(hif.in_a);
        BQ      <= onehot4(hif.in_b);
        carryin <= dr_encode(hif.in_cin);
      end else if (tx_next != TX_DATA) begin
        AQ      <= '0;
        BQ      <= '0;
        carryin <= '0;
      end
    end
  end

  // ---- decoded result register ----
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
    end else if (rx_load) begin
      out_valid <= 1'b1;
      out_sum   <= decode4(sumq_s);
      out_cout  <= dr_decode(cout_s);
    end else if (out_valid && hif.out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign hif.in_ready  = in_ready;
  assign hif.out_valid = out_valid;
  assign hif.out_sum   = out_sum;
  assign hif.out_cout  = out_cout;

  assign idle_both = (tx_state == TX_IDLE) && (rx_state == RX_WAIT);
  assign st_change = (tx_next != tx_state) || (rx_next != rx_state);

  // ---- progress watchdog ----
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      tmo_cnt     <= '0;
      err_timeout <= 1'b0;
    end else if (st_change || idle_both) begin
      tmo_cnt     <= '0;
    end else if (tmo_cnt != CW'(TMO_CYCLES)) begin
      tmo_cnt     <= tmo_cnt + CW'(1);
      if (tmo_cnt == CW'(TMO_CYCLES - 1)) err_timeout <= 1'b1;
    end
  end

endmodule

// File: doc/ncl_quad_adder_host.md
# ncl_quad_adder_host

Clocked host for one quaternary NCL full-adder digit. It encodes binary operands into 1-of-4 / dual-rail DATA wavefronts and drives the adder's input rails with the NULL Convention four-phase protocol. It synchronises the adder's completion and result rails, then decodes sum and carry back to binary for the synchronous side. The block sits at the clocked-to-clockless boundary: it is the producer and consumer around the adder digit.

## Interface
- SYNC_STAGES, 2: flops per synchroniser on every asynchronous input (≥2)
- TMO_CYCLES, 1024: cycles without handshake progress before timeout (≥4)
- clk  in  1  clock
- init_n  in  1  asynchronous, active-low reset
- in_valid / in_ready  in/out  1/1  operand handshake (valid/ready)
- in_a, in_b  in  2 each  operand digits 0..3
- in_cin  in  1  carry-in
- out_valid / out_ready  out/in  1/1  result handshake (valid/ready)
- out_sum  out  2  sum digit
- out_cout  out  1  carry-out
- AQ, BQ  out  4 each  1-of-4 operand rails to adder
- carryin  out  2  dual-rail carry (rail0 = 0, rail1 = 1)
- ABCOMP  in  1  adder operand-rank completion (asynchronous)
- sumcarryCOMP  in  1  adder output-stage completion (asynchronous)
- sumQ  in  4  1-of-4 sum rails (asynchronous)
- carryout  in  2  dual-rail carry-out (asynchronous)
- sumCOMP, carryCOMP  out  1 each  acknowledge to adder; 1 = DATA consumed
- err_timeout, err_rail  out  1 each  sticky error flags

## Operation
- All NCL-side outputs come directly from flops. All NCL-side inputs pass through SYNC_STAGES synchronisers; the FSMs use only synchronised values (*_s).
- Transmit FSM:
  - TX_IDLE: rails NULL. in_ready = ABCOMP_s==0 && sumcarryCOMP_s==0. On accept, go to TX_DATA.
  - TX_DATA: AQ = onehot(in_a), BQ = onehot(in_b), carryin = onehot(in_cin), registered at accept. When ABCOMP_s && sumcarryCOMP_s, go to TX_RTZ.
  - TX_RTZ: all rails 0. When !ABCOMP_s && !sumcarryCOMP_s, go to TX_IDLE.
- Receive FSM:
  - RX_WAIT: sumCOMP = carryCOMP = 0. When sumQ_s has exactly one rail set, carryout_s has exactly one rail set, and the output register is free (out_valid==0, or out_ready this cycle): load out_sum = index of the set rail, out_cout = carryout_s[1]; set out_valid; go to RX_ACK.
  - RX_ACK: sumCOMP = carryCOMP = 1. When sumQ_s==0 && carryout_s==0, go to RX_WAIT.
  - A partial wavefront (zero rails set) is incomplete: wait.
- Output register: out_valid clears on out_valid && out_ready unless reloaded in the same cycle.
- Timeout: one counter, cleared on every TX or RX state change and in TX_IDLE+RX_WAIT. Reaching TMO_CYCLES sets err_timeout. The FSMs keep waiting; no recovery.
- Arithmetic reference: out_sum + 4·out_cout = in_a + in_b + in_cin, range 0..7.

## Timing
- Reset (init_n low, asynchronous): TX_IDLE, RX_WAIT; AQ = BQ = 0, carryin = 0, sumCOMP = carryCOMP = 0; out_valid = 0, out_sum = 0, out_cout = 0, in_ready = 0; errors = 0; counter = 0.
- in_ready rises the first cycle after reset release in which the synchronised completions read 0.
- DATA rails are driven in cycle t+1 after an accept in cycle t.
- Each phase edge costs SYNC_STAGES+1 cycles of synchroniser and FSM latency plus adder delay.
- Minimum accept-to-out_valid: 1 + SYNC_STAGES + 1 cycles plus adder delay.
- Throughput: at most one operand per full four-phase cycle. TX and RX run concurrently. TX never waits on out_ready. The adder holds DATA, so back-pressure stalls at sumcarryCOMP.
- Reset mid-phase: rails return to NULL immediately. The adder must also be in init; the system guarantees this.

## Configuration
- NCL_QHOST_RAILCHK_EN defined: any synchronised sumQ with ≥2 rails set, or carryout with both rails set, sets err_rail (sticky). The FSM treats such a wavefront as incomplete.
- NCL_QHOST_RAILCHK_EN undefined: err_rail tied 0. Completeness is any-rail-set, and decode uses the lowest set rail.

## Structure
- Package ncl_qhost_pkg:
  - tx_state_t, rx_state_t enums
  - onehot4/decode4 and dual-rail encode/decode functions
  - Q_WIDTH = 4, DR_WIDTH = 2
- Sub-module ncl_sync: parameterised SYNC_STAGES flop chain, async-cleared by init_n. It is instantiated per asynchronous input bit.

## Test plan
- Reset, then in_a=3, in_b=2, in_cin=1 -> AQ=4'b1000, BQ=4'b0100, carryin=2'b10; out_sum=2, out_cout=1, out_valid=1.
- in_a=0, in_b=0, in_cin=0 -> AQ=BQ=4'b0001; out_sum=0, out_cout=0; sumCOMP rises only after sumQ DATA, falls after sumQ NULL.
- Hold out_ready=0 across two operands (1+1+0, 3+3+1) -> first result 2/0 held; sumCOMP stays 0 and in_ready stays 0 until out_ready, then second result 3/1.
- Adder model never raises ABCOMP -> err_timeout=1 exactly TMO_CYCLES cycles after entering TX_DATA; rails stay DATA.
- With NCL_QHOST_RAILCHK_EN, force sumQ=4'b0101 -> err_rail=1, no out_valid. Without the macro, err_rail stays 0.
- init_n low during TX_DATA -> rails 0 asynchronously; after release, a fresh 2+1+0 gives out_sum=3, out_cout=0.
